// File: rtl/mem_bus_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mem_bus_arbiter_pkg
//  Purpose  : Shared encodings and helpers for the IF/DM unified-RAM arbiter.
//  Revision : 1.0  initial release
// ============================================================================
package mem_bus_arbiter_pkg;

    localparam logic [1:0]  ARB_IDLE       = 2'd0;
    localparam logic [1:0]  ARB_IF_BUSY    = 2'd1;
    localparam logic [1:0]  ARB_DM_BUSY    = 2'd2;

    localparam logic [31:0] ARB_ABORT_DATA = 32'hDEAD_BEEF;
    localparam int          DM_ADDR_W      = 16;

    // Saturating increment for the DM streak counter.
    function automatic int streak_next(input int cur, input int max_val);
        return (cur >= max_val) ? cur : cur + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_bus_arbiter_wait_timer.sv
`default_nettype none
// ============================================================================
//  Module   : arb_wait_timer
//  Purpose  : Counts BUSY cycles without an acknowledge and flags expiry.
//  Revision : 1.0  initial release
// ============================================================================
module arb_wait_timer
    import mem_bus_arbiter_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic clk,
    input  logic int_rst_n,
    input  logic i_clear,
    input  logic i_inc,
    output logic o_expired
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge int_rst_n) begin
        if (!int_rst_n) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_inc) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_expired = (r_cnt == CNT_W'(TIMEOUT - 1));

endmodule
`default_nettype wire

// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_bus_arbiter
//  Purpose  : Shares a single-port RAM between fetch (IF) and data (DM)
//             with DM priority, IF anti-starvation and a wait timeout.
//  Revision : 1.0  initial release
// ============================================================================
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int DM_MAX_STREAK = 4,
    parameter int TIMEOUT       = 16,
    parameter int CNT_W         = 5
) (
    input  logic                 clk,
    input  logic                 int_rst_n,
    input  logic                 if_req,
    input  logic [31:0]          if_addr,
    output logic [31:0]          if_rdata,
    output logic                 if_valid,
    input  logic                 dm_req,
    input  logic                 dm_read_wrn,
    input  logic [DM_ADDR_W-1:0] dm_addr,
    input  logic [31:0]          dm_wdata,
    output logic [31:0]          dm_rdata,
    output logic                 dm_valid,
    output logic                 mem_req,
    output logic                 mem_read_wrn,
    output logic [31:0]          mem_addr,
    output logic [31:0]          mem_wdata,
    input  logic [31:0]          mem_rdata,
    input  logic                 mem_ack,
    output logic                 halt,
    output logic                 timeout_err
);

    localparam int c_STREAK_W = $clog2(DM_MAX_STREAK + 1);

    logic [1:0]            r_state;
    logic [c_STREAK_W-1:0] r_dm_streak;

    logic w_busy;
    logic w_expired;
    logic w_abort;
    logic w_done;
    logic w_arb_en;
    logic w_if_cand;
    logic w_dm_cand;
    logic w_grant_dm;
    logic w_grant_if;

    assign w_busy   = (r_state == ARB_IF_BUSY) || (r_state == ARB_DM_BUSY);
    assign w_abort  = w_busy && !mem_ack && w_expired;
    assign w_done   = w_busy && (mem_ack || w_abort);
    assign w_arb_en = (r_state == ARB_IDLE) || w_done;

    // A request whose valid is showing, or whose transaction completes on
    // this edge, is already served and must not be granted again.
    assign w_if_cand = if_req && !if_valid && !(w_done && (r_state == ARB_IF_BUSY));
    assign w_dm_cand = dm_req && !dm_valid && !(w_done && (r_state == ARB_DM_BUSY));

    assign w_grant_dm = w_arb_en && w_dm_cand &&
                        (!w_if_cand || (r_dm_streak < c_STREAK_W'(DM_MAX_STREAK)));
    assign w_grant_if = w_arb_en && w_if_cand && !w_grant_dm;

    assign halt = int_rst_n && ((if_req && !if_valid) || (dm_req && !dm_valid));

    arb_wait_timer #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_wait_timer (
        .clk       (clk),
        .int_rst_n (int_rst_n),
        .i_clear   (w_grant_dm || w_grant_if || w_done),
        .i_inc     (w_busy && !mem_ack),
        .o_expired (w_expired)
    );

    always_ff @(posedge clk or negedge int_rst_n) begin
        if (!int_rst_n) begin
            r_state      <= ARB_IDLE;
            r_dm_streak  <= '0;
            if_rdata     <= '0;
            if_valid     <= 1'b0;
            dm_rdata     <= '0;
            dm_valid     <= 1'b0;
            mem_req      <= 1'b0;
            mem_read_wrn <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            timeout_err  <= 1'b0;
        end else begin
            if_valid <= 1'b0;
            dm_valid <= 1'b0;

            if (w_done) begin
                if (r_state == ARB_IF_BUSY) begin
                    if_valid <= 1'b1;
                    if_rdata <= w_abort ? ARB_ABORT_DATA : mem_rdata;
                end else begin
                    dm_valid <= 1'b1;
                    // mem_read_wrn still holds the DM owner's direction here
                    dm_rdata <= w_abort ? ARB_ABORT_DATA :
                                (mem_read_wrn ? mem_rdata : 32'h0);
                end
                if (w_abort) begin
                    timeout_err <= 1'b1;
                end
            end

            if (w_grant_dm) begin
                r_state      <= ARB_DM_BUSY;
                r_dm_streak  <= c_STREAK_W'(streak_next(32'(r_dm_streak), DM_MAX_STREAK));
                mem_req      <= 1'b1;
                mem_read_wrn <= dm_read_wrn;
                mem_addr     <= {{(32 - DM_ADDR_W){1'b0}}, dm_addr};
                mem_wdata    <= dm_wdata;
            end else if (w_grant_if) begin
                r_state      <= ARB_IF_BUSY;
                r_dm_streak  <= '0;
                mem_req      <= 1'b1;
                mem_read_wrn <= 1'b1;
                mem_addr     <= if_addr;
                mem_wdata    <= 32'h0;
            end else if (w_done) begin
                r_state <= ARB_IDLE;
                mem_req <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_bus_arbiter
//  Purpose  : Randomized bench for mem_bus_arbiter with a transaction-level
//             reference model of ownership, grants, timeouts and halt.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mem_bus_arbiter;

    localparam int DM_MAX_STREAK = 4;
    localparam int TIMEOUT       = 16;
    localparam int CNT_W         = 5;

    logic        clk = 1'b0;
    logic        int_rst_n;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_valid;
    logic        dm_req;
    logic        dm_read_wrn;
    logic [15:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;
    logic        dm_valid;
    logic        mem_req;
    logic        mem_read_wrn;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        halt;
    logic        timeout_err;

    always #5 clk = ~clk;

    mem_bus_arbiter #(
        .DM_MAX_STREAK (DM_MAX_STREAK),
        .TIMEOUT       (TIMEOUT),
        .CNT_W         (CNT_W)
    ) dut (
        .clk          (clk),
        .int_rst_n    (int_rst_n),
        .if_req       (if_req),
        .if_addr      (if_addr),
        .if_rdata     (if_rdata),
        .if_valid     (if_valid),
        .dm_req       (dm_req),
        .dm_read_wrn  (dm_read_wrn),
        .dm_addr      (dm_addr),
        .dm_wdata     (dm_wdata),
        .dm_rdata     (dm_rdata),
        .dm_valid     (dm_valid),
        .mem_req      (mem_req),
        .mem_read_wrn (mem_read_wrn),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .mem_ack      (mem_ack),
        .halt         (halt),
        .timeout_err  (timeout_err)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: who owns the RAM (0 none, 1 IF, 2 DM), how many busy
    // cycles have elapsed, and what each output should show.
    int          m_owner, m_busy, m_streak, mem_lat;
    bit          m_err, m_dm_read, m_new_grant;
    bit          e_mem_req, e_mem_rw, e_if_valid, e_dm_valid;
    logic [31:0] e_mem_addr, e_mem_wdata, e_if_rdata, e_dm_rdata;
    bit          if_pend, dm_pend;

    function automatic void model_reset();
        m_owner = 0; m_busy = 0; m_streak = 0; m_err = 0; m_dm_read = 0;
        m_new_grant = 0; e_mem_req = 0; e_mem_rw = 0; e_if_valid = 0; e_dm_valid = 0;
        e_mem_addr = 0; e_mem_wdata = 0; e_if_rdata = 0; e_dm_rdata = 0;
    endfunction

    function automatic void model_edge();
        bit if_c, dm_c, done, abort;
        if_c = if_req && !e_if_valid;
        dm_c = dm_req && !e_dm_valid;
        done = 0; abort = 0; m_new_grant = 0;
        e_if_valid = 0; e_dm_valid = 0;
        if (m_owner != 0) begin
            m_busy++;
            if (mem_ack) done = 1;
            else if (m_busy == TIMEOUT) begin done = 1; abort = 1; end
        end
        if (done) begin
            if (m_owner == 1) begin
                if_c = 0; e_if_valid = 1;
                e_if_rdata = abort ? 32'hDEAD_BEEF : mem_rdata;
            end else begin
                dm_c = 0; e_dm_valid = 1;
                e_dm_rdata = abort ? 32'hDEAD_BEEF : (m_dm_read ? mem_rdata : 32'h0);
            end
            if (abort) m_err = 1;
            m_owner = 0; e_mem_req = 0;
        end
        if (m_owner == 0) begin
            if (dm_c && (!if_c || m_streak < DM_MAX_STREAK)) begin
                m_owner = 2; m_busy = 0; m_new_grant = 1;
                if (m_streak < DM_MAX_STREAK) m_streak++;
                e_mem_req = 1; e_mem_rw = dm_read_wrn; m_dm_read = dm_read_wrn;
                e_mem_addr = {16'h0, dm_addr}; e_mem_wdata = dm_wdata;
            end else if (if_c) begin
                m_owner = 1; m_busy = 0; m_new_grant = 1; m_streak = 0;
                e_mem_req = 1; e_mem_rw = 1; e_mem_addr = if_addr; e_mem_wdata = 0;
            end
        end
    endfunction

    task automatic drive(input int p_if, input int p_dm, input int p_never);
        int r;
        if (e_if_valid) begin
            if_pend = 0;
            if ($urandom_range(0, 1) == 0) if_req = 0;
        end else if (!if_pend) begin
            if ($urandom_range(0, 99) < p_if) begin
                if_req = 1; if_addr = $urandom; if_pend = 1;
            end else begin
                if_req = 0;
            end
        end else if (m_owner == 1) begin
            if_addr = $urandom;
        end

        if (e_dm_valid) begin
            dm_pend = 0;
            if ($urandom_range(0, 1) == 0) dm_req = 0;
        end else if (!dm_pend) begin
            if ($urandom_range(0, 99) < p_dm) begin
                dm_req = 1; dm_read_wrn = 1'($urandom_range(0, 1));
                dm_addr = 16'($urandom); dm_wdata = $urandom; dm_pend = 1;
            end else begin
                dm_req = 0;
            end
        end else if (m_owner == 2) begin
            dm_addr = 16'($urandom); dm_wdata = $urandom; dm_read_wrn = ~dm_read_wrn;
        end

        if (m_new_grant) begin
            r = $urandom_range(0, 99);
            if (r < p_never)           mem_lat = 1000;
            else if (r < p_never + 8)  mem_lat = TIMEOUT - 1;
            else if (r < p_never + 12) mem_lat = TIMEOUT - 2;
            else                       mem_lat = $urandom_range(0, 3);
        end
        mem_ack   = (m_owner != 0) && (m_busy == mem_lat);
        mem_rdata = $urandom;
    endtask

    task automatic compare_regs();
        check("mem_req", 32'(mem_req), 32'(e_mem_req));
        check("if_valid", 32'(if_valid), 32'(e_if_valid));
        check("dm_valid", 32'(dm_valid), 32'(e_dm_valid));
        check("timeout_err", 32'(timeout_err), 32'(m_err));
        if (e_mem_req) begin
            check("mem_addr", mem_addr, e_mem_addr);
            check("mem_read_wrn", 32'(mem_read_wrn), 32'(e_mem_rw));
            check("mem_wdata", mem_wdata, e_mem_wdata);
        end
        if (e_if_valid) check("if_rdata", if_rdata, e_if_rdata);
        if (e_dm_valid) check("dm_rdata", dm_rdata, e_dm_rdata);
    endtask

    task automatic cycle(input int p_if, input int p_dm, input int p_never);
        drive(p_if, p_dm, p_never);
        #1;
        check("halt", 32'(halt),
              32'(int_rst_n && ((if_req && !e_if_valid) || (dm_req && !e_dm_valid))));
        model_edge();
        @(posedge clk);
        #1;
        compare_regs();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_mem_req"}, 32'(mem_req), 32'h0);
        check({tag, "_halt"}, 32'(halt), 32'h0);
        check({tag, "_if_valid"}, 32'(if_valid), 32'h0);
        check({tag, "_dm_valid"}, 32'(dm_valid), 32'h0);
        check({tag, "_timeout_err"}, 32'(timeout_err), 32'h0);
        check({tag, "_mem_addr"}, mem_addr, 32'h0);
        check({tag, "_mem_wdata"}, mem_wdata, 32'h0);
        check({tag, "_mem_read_wrn"}, 32'(mem_read_wrn), 32'h0);
        check({tag, "_if_rdata"}, if_rdata, 32'h0);
        check({tag, "_dm_rdata"}, dm_rdata, 32'h0);
    endtask

    // Asserts reset asynchronously in the middle of an active transaction.
    task automatic mid_reset();
        int k;
        k = 0;
        while (!e_mem_req && k < 200) begin
            cycle(60, 60, 0);
            k++;
        end
        #2;
        int_rst_n = 1'b0;
        #1;
        check_all_zero("rst_async");
        model_reset();
        mem_ack = 1'b0;
        if_pend = if_req;
        dm_pend = dm_req;
        @(posedge clk);
        #1;
        check("rst_hold_mem_req", 32'(mem_req), 32'h0);
        @(negedge clk);
        int_rst_n = 1'b1;
    endtask

    initial begin
        int_rst_n   = 1'b0;
        if_req      = 1'b1;
        if_addr     = 32'h0000_0100;
        dm_req      = 1'b1;
        dm_read_wrn = 1'b0;
        dm_addr     = 16'h0040;
        dm_wdata    = 32'hA5A5_A5A5;
        mem_rdata   = 32'h0;
        mem_ack     = 1'b0;
        mem_lat     = 0;
        if_pend     = 1'b1;
        dm_pend     = 1'b1;
        model_reset();

        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        int_rst_n = 1'b1;

        repeat (400) cycle(30, 30, 0);
        repeat (600) cycle(100, 100, 0);
        repeat (800) cycle(50, 50, 30);
        mid_reset();
        repeat (400) cycle(40, 40, 5);
        mid_reset();
        repeat (300) cycle(70, 70, 10);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
